// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time,
// skids a returned word while decode is stalled, and applies delayed-branch redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jmp_sig,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        ir_valid
);

    typedef enum logic [0:0] {
        StFetch,
        StBuf
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] buf_ir_q, buf_ir_d;
    logic [31:0] tgt_q, tgt_d;
    logic        tgt_pend_q, tgt_pend_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        req_q, req_d;

    logic        acc;
    logic        redir;
    logic        load;
    logic [31:0] fpc_inc;
    logic [31:0] next_pc;
    logic [31:0] load_word;

    // IF/ID may take a new instruction when it is empty or decode is consuming it.
    assign acc     = !ir_valid_q || !stall;
    // A branch in IF/ID only redirects in the cycle decode actually consumes it.
    assign redir   = ir_valid_q && !stall && jmp_sig;
    assign fpc_inc = fpc_q + 32'd4;

    // Decide whether an instruction enters IF/ID and where the following fetch goes.
    always_comb begin
        load      = 1'b0;
        load_word = imem_data;
        if (state_q == StFetch) begin
            load      = imem_ack && acc;
            load_word = imem_data;
        end else begin
            load      = acc;
            load_word = buf_ir_q;
        end

        // The entering word is the delay slot of any branch consumed now, so the
        // branch target becomes the address after it.
        if (redir) begin
            next_pc = jmp_addr;
        end else if (tgt_pend_q) begin
            next_pc = tgt_q;
        end else begin
            next_pc = fpc_inc;
        end
    end

    // Next-state for the fetch FSM, skid buffer, pending target and IF/ID.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        buf_ir_d   = buf_ir_q;
        tgt_d      = tgt_q;
        tgt_pend_d = tgt_pend_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        ir_valid_d = ir_valid_q;

        if (load) begin
            ir_d       = load_word;
            pc_d       = fpc_inc;
            ir_valid_d = 1'b1;
            fpc_d      = next_pc;
            state_d    = StFetch;
            if (!redir) begin
                tgt_pend_d = 1'b0;
            end
        end else if (acc) begin
            // Decode drained IF/ID but nothing arrived: bubble, and remember any
            // redirect until the delay slot shows up.
            ir_valid_d = 1'b0;
            if (redir) begin
                tgt_d      = jmp_addr;
                tgt_pend_d = 1'b1;
            end
        end

        // Word returned while decode is stalled: park it, fpc keeps pointing at it.
        if ((state_q == StFetch) && imem_ack && !acc) begin
            buf_ir_d = imem_data;
            state_d  = StBuf;
        end

        req_d = (state_d == StFetch);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            fpc_q      <= RESET_PC;
            buf_ir_q   <= 32'd0;
            tgt_q      <= 32'd0;
            tgt_pend_q <= 1'b0;
            ir_q       <= 32'd0;
            pc_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            buf_ir_q   <= buf_ir_d;
            tgt_q      <= tgt_d;
            tgt_pend_q <= tgt_pend_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fpc_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps from the fetch scenarios, then random
// stall/ack/branch traffic checked against a program-order reference model.
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jmp_sig;
    logic [31:0] jmp_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: instruction i in program order lives at addr_of[i];
    // redirect[i] forces the address of instruction i (branch index + 2).
    logic [31:0] addr_of  [int];
    logic [31:0] redirect [int];
    int          n_fetched;
    int          n_entered;
    bit          m_valid;
    bit          m_buf;

    fetch_unit #(
        .RESET_PC(RstPc)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .jmp_sig  (jmp_sig),
        .jmp_addr (jmp_addr),
        .imem_req (imem_req),
        .imem_addr(imem_addr),
        .imem_ack (imem_ack),
        .imem_data(imem_data),
        .ir       (ir),
        .pc       (pc),
        .ir_valid (ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h2408_0001 ^ ((a ^ 32'h0000_0100) * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] fetch_addr(input int idx);
        if (redirect.exists(idx)) return redirect[idx];
        if (idx == 0) return RstPc;
        return addr_of[idx-1] + 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        addr_of.delete();
        redirect.delete();
        n_fetched = 0;
        n_entered = 0;
        m_valid   = 1'b0;
        m_buf     = 1'b0;
    endtask

    // Hold reset for n edges (optionally with a stray ack), check, then release.
    task automatic do_reset(input int n, input bit ack_during);
        @(negedge clk);
        rst_n     = 1'b0;
        stall     = 1'b0;
        jmp_sig   = 1'b0;
        imem_ack  = ack_during;
        imem_data = $urandom();
        repeat (n) @(posedge clk);
        #1;
        model_clear();
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, RstPc);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input bit st, input bit ack_en, input bit js, input logic [31:0] ja);
        bit          acc;
        bit          acked;
        logic [31:0] cur;
        @(negedge clk);
        chk("req", 32'(imem_req), 32'(!m_buf));
        if (!m_buf) chk("addr", imem_addr, fetch_addr(n_fetched));
        chk("valid", 32'(ir_valid), 32'(m_valid));
        if (m_valid) begin
            cur = addr_of[n_entered-1];
            chk("ir", ir, memf(cur));
            chk("pc", pc, cur + 32'd4);
        end

        acked     = ack_en && imem_req;
        stall     = st;
        jmp_sig   = js;
        jmp_addr  = ja;
        imem_ack  = acked;
        imem_data = acked ? memf(imem_addr) : $urandom();

        acc = !m_valid || !st;
        if (m_valid && !st && js) redirect[n_entered+1] = ja;
        if (acked) begin
            addr_of[n_fetched] = fetch_addr(n_fetched);
            n_fetched++;
        end
        if (acc) begin
            if (m_buf || acked) begin
                m_valid = 1'b1;
                m_buf   = 1'b0;
                n_entered++;
            end else begin
                m_valid = 1'b0;
            end
        end else if (acked) begin
            m_buf = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        bit          st;
        bit          ak;
        bit          js;
        logic [31:0] ja;

        rst_n     = 1'b0;
        stall     = 1'b0;
        jmp_sig   = 1'b0;
        jmp_addr  = 32'd0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        model_clear();

        // Reset and first fetch.
        do_reset(2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("first_ir", ir, 32'h2408_0001);
        chk("first_pc", pc, 32'h0000_0104);
        chk("first_next_addr", imem_addr, 32'h0000_0104);

        // Stall skid: ack for 0x104 lands during a 3-cycle stall.
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        chk("skid_req", 32'(imem_req), 32'd0);
        chk("skid_hold_ir", ir, 32'h2408_0001);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("skid_ir", ir, memf(32'h104));
        chk("skid_pc", pc, 32'h0000_0108);
        chk("skid_addr", imem_addr, 32'h0000_0108);

        // Stream 0x108, then zero-wait redirect with branch at 0x108.
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("stream_ir", ir, memf(32'h108));
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        #1;
        chk("zw_slot_ir", ir, memf(32'h10C));
        chk("zw_slot_pc", pc, 32'h0000_0110);
        chk("zw_tgt_addr", imem_addr, 32'h0000_0200);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("zw_tgt_ir", ir, memf(32'h200));
        chk("zw_tgt_pc", pc, 32'h0000_0204);

        // Delayed redirect: branch at 0x200 consumed while 0x204 is still pending.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        #1;
        chk("dly_bubble", 32'(ir_valid), 32'd0);
        chk("dly_wait_addr", imem_addr, 32'h0000_0204);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("dly_slot_ir", ir, memf(32'h204));
        chk("dly_slot_pc", pc, 32'h0000_0208);
        chk("dly_tgt_addr", imem_addr, 32'h0000_0300);

        // Stall together with jmp_sig: redirect must be ignored.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("stjmp_ir", ir, memf(32'h300));
        chk("stjmp_addr", imem_addr, 32'h0000_0304);

        // Reset while waiting at 0x304 with an ack on the reset edge.
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset(1, 1'b1);

        // Wrap: branch to 0xFFFF_FFFC, the following fetch wraps to 0.
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("wrap_ir", ir, memf(32'd0));
        chk("wrap_pc4", pc, 32'd4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset(1, 1'($urandom_range(0, 1)));
            st = ($urandom_range(0, 99) < 30);
            ak = ($urandom_range(0, 99) < 60);
            js = ($urandom_range(0, 99) < 20);
            ja = $urandom() & 32'hFFFF_FFFC;
            cycle(st, ak, js, ja);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 5-stage MIPS core. Holds the program counter, fetches one word per transaction over a req/ack instruction-memory port, and drives the IF/ID register (`ir`, `pc`) into decode. It consumes decode's redirect (`jmp_sig`, `jmp_addr`) with MIPS one-instruction delay-slot semantics and honours the decode stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `stall`  in  1: decode cannot accept a new instruction this cycle. IF/ID holds.
- `jmp_sig`  in  1: instruction in IF/ID is a taken branch/jump. Meaningful only when `ir_valid && !stall`.
- `jmp_addr`  in  32: redirect target, word-aligned.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address. Equals internal PC.
- `imem_ack`  in  1: `imem_data` is valid this cycle. May assert in the same cycle as `imem_req`.
- `imem_data`  in  32: fetched word.
- `ir`  out  32: IF/ID instruction.
- `pc`  out  32: IF/ID address of the instruction + 4. This is the branch base used by decode.
- `ir_valid`  out  1: IF/ID holds a real instruction.

## Operation
- State: `FETCH` (request outstanding) and `BUF` (word captured in the skid buffer; decode was stalled).
- Internal registers: `fpc` (fetch PC), `buf_ir`, `tgt`, `tgt_pend`.
- Accept condition: `acc = !ir_valid || !stall`. IF/ID may load this cycle.
- **FETCH**
  - `imem_req` = 1 and `imem_addr` = `fpc`. Both are held stable until ack.
  - On `imem_ack && acc`: IF/ID <= {`imem_data`, `fpc`+4, valid}. `fpc` <= next address. Stay in FETCH.
  - On `imem_ack && !acc`: `buf_ir` <= `imem_data`. Go to BUF. `fpc` is unchanged.
  - No ack and `acc`: `ir_valid` <= 0.
- **BUF**
  - `imem_req` = 0.
  - When `acc`: IF/ID <= {`buf_ir`, `fpc`+4, valid}. `fpc` <= next address. Go to FETCH.
- Next address when an instruction enters IF/ID:
  - If a redirect is being consumed this cycle (`ir_valid && !stall && jmp_sig`), next = `jmp_addr`.
  - Else if `tgt_pend`, next = `tgt`, and clear `tgt_pend`.
  - Else next = `fpc`+4. Arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Redirect consumed but no instruction enters IF/ID that cycle: `tgt` <= `jmp_addr`, `tgt_pend` <= 1, `ir_valid` <= 0.
- Delay slot: the instruction entering IF/ID right after a branch is always the word at branch+4. It is never squashed. The target is fetched next.
- Invariant: `fpc` always addresses the next instruction to enter IF/ID. At most one fetch is outstanding.
- `jmp_sig` is ignored when `!ir_valid` or `stall`.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `fpc`=`RESET_PC`, state FETCH.
  - `ir_valid`=0, `ir`=0, `pc`=0.
  - `tgt_pend`=0, `buf_ir`=0.
  - `imem_req`=1 from the first cycle after reset.
- Reset mid-transaction: an in-flight ack is dropped. Memory must tolerate the request being reissued at `RESET_PC`.
- Throughput: one instruction per cycle with zero-wait ack.
- Latency: ack at edge N puts the instruction in IF/ID (`ir_valid`=1) after edge N.
- Redirect: with zero-wait memory, branch in IF/ID at cycle N → delay slot in IF/ID at N+1 → target in IF/ID at N+2.
- Stall with ack: the word is held in `buf_ir`. It enters IF/ID on the first edge with `acc`=1.
- Stall and `jmp_sig` together: no redirect is taken. The branch stays in IF/ID and is re-evaluated.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `RESET_PC`=32'h0000_0100, then release. Expect `imem_req`=1, `imem_addr`=0x100, `ir_valid`=0. Ack with 0x2408_0001. Next cycle expect `ir`=0x2408_0001, `pc`=0x104.
- **Streaming:** ack every cycle. Expect `imem_addr` sequence 0x100, 0x104, 0x108, 0x10C, with one instruction per cycle.
- **Stall skid:** assert `stall` for 3 cycles while ack arrives for 0x104. Expect `imem_req`=0 during BUF and IF/ID unchanged. When stall drops, expect `ir` = data@0x104 and `pc`=0x108.
- **Zero-wait redirect:** branch at 0x108 in IF/ID, `jmp_sig`=1, `jmp_addr`=0x200, with 0x10C acked the same cycle. Expect `ir`=delay slot and `pc`=0x110. Expect the next `imem_addr`=0x200, then the target enters IF/ID.
- **Delayed redirect:** same as above, but ack for 0x10C arrives 2 cycles late.
  - Expect `tgt_pend`=1 and `ir_valid`=0 in between.
  - Then the delay slot enters IF/ID, then `imem_addr`=0x200.
- **Reset mid-wait:** assert reset while FETCH waits at 0x10C, then ack on the same edge. Expect `ir_valid`=0 and `imem_addr`=`RESET_PC`. The late ack is ignored.
